// File: rtl/rv_plic_gateway_mc_if.sv
// Interface bundle for rv_plic_gateway_mc: raw sources, per-source mode,
// the claim/complete handshake from the PLIC target and the gateway's
// pending/active/overflow outputs.
// master = PLIC/target side driving sources and handshakes, slave = gateway.
interface rv_plic_gateway_mc_if #(
   parameter int N_SOURCE = 32
);
   logic [N_SOURCE-1:0]   src_i;
   logic [2*N_SOURCE-1:0] mode_i;
   logic [N_SOURCE-1:0]   claim_i;
   logic [N_SOURCE-1:0]   complete_i;
   logic [N_SOURCE-1:0]   ovf_clr_i;
   logic [N_SOURCE-1:0]   ip_o;
   logic [N_SOURCE-1:0]   ia_o;
   logic [N_SOURCE-1:0]   ovf_o;

   modport master (
      output src_i, mode_i, claim_i, complete_i, ovf_clr_i,
      input  ip_o, ia_o, ovf_o
   );

   modport slave (
      input  src_i, mode_i, claim_i, complete_i, ovf_clr_i,
      output ip_o, ia_o, ovf_o
   );
endinterface

// File: rtl/rv_plic_gateway_mc.sv
// rv_plic_gateway_mc: multi-mode PLIC interrupt gateway.
// Each source is synchronised, turned into a trigger event according to its
// mode (level / rising / falling / both edges) and tracked by a small
// IDLE -> PEND -> SERV state machine whose encoding is {ia, ip}.
// Optional feature macro RV_PLIC_GW_EDGE_CNT_EN: when defined, edges arriving
// while a source is busy are queued in a saturating CNT_W-bit counter; when
// undefined, such edges are dropped and only flag overflow.
module rv_plic_gateway_mc #(
   parameter int N_SOURCE    = 32,
   parameter int CNT_W       = 2,
   parameter int SYNC_STAGES = 2
) (
   input logic clk_i,
   input logic rst_ni,
   rv_plic_gateway_mc_if.slave gw
);

   localparam logic [1:0] MODE_LEVEL = 2'b00;
   localparam logic [1:0] MODE_RISE  = 2'b01;
   localparam logic [1:0] MODE_FALL  = 2'b10;
   localparam logic [1:0] MODE_BOTH  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SERV = 2'b10,
      PEND = 2'b11
   } state_e;

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("rv_plic_gateway_mc: CNT_W must be at least 1");
   end

   logic [N_SOURCE-1:0] s;
   logic [N_SOURCE-1:0] p_q;
   logic [N_SOURCE-1:0] p_d;
   logic [N_SOURCE-1:0] set_ev;
   logic [N_SOURCE-1:0] edge_mode;
   logic [N_SOURCE-1:0] queue_evt;
   logic [N_SOURCE-1:0] ovf_q;
   logic [N_SOURCE-1:0] ovf_d;
   state_e              state_q [N_SOURCE];
   state_e              state_d [N_SOURCE];

`ifdef RV_PLIC_GW_EDGE_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   logic [CNT_W-1:0] cnt_q [N_SOURCE];
   logic [CNT_W-1:0] cnt_d [N_SOURCE];
`endif

   if (SYNC_STAGES == 0) begin : g_no_sync
      assign s = gw.src_i;
   end else begin : g_sync
      logic [SYNC_STAGES-1:0][N_SOURCE-1:0] sync_q;
      logic [SYNC_STAGES-1:0][N_SOURCE-1:0] sync_d;

      // Shift raw sources one stage further down the synchroniser chain
      always_comb begin
         sync_d[0] = gw.src_i;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
         end
      end

      // Synchroniser flops, cleared on reset
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            sync_q <= '0;
         end else begin
            sync_q <= sync_d;
         end
      end

      assign s = sync_q[SYNC_STAGES-1];
   end

   assign p_d = s;

   // Trigger event per source, selected by its mode bits
   always_comb begin
      set_ev    = '0;
      edge_mode = '0;
      for (int i = 0; i < N_SOURCE; i++) begin
         edge_mode[i] = (gw.mode_i[2*i +: 2] != MODE_LEVEL);
         unique case (gw.mode_i[2*i +: 2])
            MODE_LEVEL: set_ev[i] = s[i];
            MODE_RISE:  set_ev[i] = s[i] & ~p_q[i];
            MODE_FALL:  set_ev[i] = ~s[i] & p_q[i];
            MODE_BOTH:  set_ev[i] = s[i] ^ p_q[i];
            default:    set_ev[i] = 1'b0;
         endcase
      end
   end

   // Next state, edge queueing and sticky overflow for every source
   always_comb begin
      ovf_d     = ovf_q & ~gw.ovf_clr_i;
      queue_evt = '0;
      for (int i = 0; i < N_SOURCE; i++) begin
         state_d[i] = state_q[i];
`ifdef RV_PLIC_GW_EDGE_CNT_EN
         cnt_d[i] = cnt_q[i];
`endif
         unique case (state_q[i])
            IDLE: begin
               if (set_ev[i]) state_d[i] = PEND;
            end
            PEND: begin
               if (gw.claim_i[i]) state_d[i] = SERV;
               queue_evt[i] = set_ev[i] & edge_mode[i];
            end
            SERV: begin
               if (gw.complete_i[i]) begin
                  if (!edge_mode[i]) begin
                     state_d[i] = IDLE;
                  end
`ifdef RV_PLIC_GW_EDGE_CNT_EN
                  else if (cnt_q[i] != '0) begin
                     state_d[i] = PEND;
                     if (!set_ev[i]) cnt_d[i] = cnt_q[i] - 1'b1;
                  end
`endif
                  else if (set_ev[i]) begin
                     state_d[i] = PEND;
                  end else begin
                     state_d[i] = IDLE;
                  end
               end else begin
                  queue_evt[i] = set_ev[i] & edge_mode[i];
               end
            end
            default: state_d[i] = IDLE;
         endcase

         if (queue_evt[i]) begin
`ifdef RV_PLIC_GW_EDGE_CNT_EN
            if (cnt_q[i] == CNT_MAX) begin
               ovf_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
`else
            ovf_d[i] = 1'b1;
`endif
         end

`ifdef RV_PLIC_GW_EDGE_CNT_EN
         if (!edge_mode[i]) cnt_d[i] = '0;
`endif
      end
   end

   // State, previous-sample, overflow and counter registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         p_q   <= '0;
         ovf_q <= '0;
         for (int i = 0; i < N_SOURCE; i++) begin
            state_q[i] <= IDLE;
`ifdef RV_PLIC_GW_EDGE_CNT_EN
            cnt_q[i] <= '0;
`endif
         end
      end else begin
         p_q   <= p_d;
         ovf_q <= ovf_d;
         for (int i = 0; i < N_SOURCE; i++) begin
            state_q[i] <= state_d[i];
`ifdef RV_PLIC_GW_EDGE_CNT_EN
            cnt_q[i] <= cnt_d[i];
`endif
         end
      end
   end

   // Pending and active outputs are the two state bits
   always_comb begin
      gw.ip_o = '0;
      gw.ia_o = '0;
      for (int i = 0; i < N_SOURCE; i++) begin
         gw.ip_o[i] = state_q[i][0];
         gw.ia_o[i] = state_q[i][1];
      end
   end

   assign gw.ovf_o = ovf_q;

endmodule

// File: tb/tb_rv_plic_gateway_mc.sv
// Testbench for rv_plic_gateway_mc: directed scenarios followed by a random
// phase, all checked against a cycle-level reference model of the gateway's
// pending / in-service / queued-edge behaviour.
module tb_rv_plic_gateway_mc;

   localparam int N       = 8;
   localparam int CNT_W   = 2;
   localparam int SYNC    = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef RV_PLIC_GW_EDGE_CNT_EN
   localparam bit EDGE_CNT = 1'b1;
`else
   localparam bit EDGE_CNT = 1'b0;
`endif

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b1;

   rv_plic_gateway_mc_if #(.N_SOURCE(N)) gwIf ();

   rv_plic_gateway_mc #(
      .N_SOURCE    (N),
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .gw     (gwIf)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;

   logic [N-1:0]   srcV  = '0;
   logic [2*N-1:0] modeV = '0;

   // Reference model state: pending, active (pending or in service),
   // queued edge count, sticky overflow, and the history of sampled sources
   bit [N-1:0] mPend;
   bit [N-1:0] mAct;
   bit [N-1:0] mOvf;
   int         mCnt [N];
   bit [N-1:0] srcHist [SYNC+1];

   function automatic logic [N-1:0] bitN(input int k);
      logic [N-1:0] v;
      v    = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   // Everything returns to idle and all history is forgotten
   function automatic void modelReset();
      mPend = '0;
      mAct  = '0;
      mOvf  = '0;
      for (int i = 0; i < N; i++) mCnt[i] = 0;
      for (int j = 0; j <= SYNC; j++) srcHist[j] = '0;
   endfunction

   // One clock edge of the gateway, computed from the behavioural rules
   function automatic void modelStep(input logic [N-1:0] claim,
                                     input logic [N-1:0] complete,
                                     input logic [N-1:0] clr);
      bit [N-1:0] nPend;
      bit [N-1:0] nAct;
      bit [N-1:0] nOvf;
      int         nCnt [N];
      bit         sNow;
      bit         sPrev;
      bit         trig;
      bit         isEdge;
      int         md;
      nPend = mPend;
      nAct  = mAct;
      nOvf  = mOvf & ~clr;
      for (int i = 0; i < N; i++) begin
         nCnt[i] = mCnt[i];
         sNow    = srcHist[SYNC-1][i];
         sPrev   = srcHist[SYNC][i];
         md      = int'(modeV[2*i +: 2]);
         isEdge  = (md != 0);
         case (md)
            0:       trig = sNow;
            1:       trig = sNow && !sPrev;
            2:       trig = !sNow && sPrev;
            default: trig = sNow != sPrev;
         endcase
         if (!mAct[i]) begin
            if (trig) begin
               nPend[i] = 1'b1;
               nAct[i]  = 1'b1;
            end
         end else if (mPend[i]) begin
            if (claim[i]) nPend[i] = 1'b0;
            if (trig && isEdge) begin
               if (EDGE_CNT && mCnt[i] < CNT_MAX) nCnt[i] = mCnt[i] + 1;
               else nOvf[i] = 1'b1;
            end
         end else begin
            if (complete[i]) begin
               if (!isEdge) nAct[i] = 1'b0;
               else if (EDGE_CNT && mCnt[i] > 0) begin
                  nPend[i] = 1'b1;
                  if (!trig) nCnt[i] = mCnt[i] - 1;
               end else if (trig) nPend[i] = 1'b1;
               else nAct[i] = 1'b0;
            end else if (trig && isEdge) begin
               if (EDGE_CNT && mCnt[i] < CNT_MAX) nCnt[i] = mCnt[i] + 1;
               else nOvf[i] = 1'b1;
            end
         end
         if (!isEdge) nCnt[i] = 0;
      end
      mPend = nPend;
      mAct  = nAct;
      mOvf  = nOvf;
      for (int i = 0; i < N; i++) mCnt[i] = nCnt[i];
      for (int j = SYNC; j > 0; j--) srcHist[j] = srcHist[j-1];
      srcHist[0] = srcV;
   endfunction

   // Compare all three output vectors with the model
   task automatic checkOutput(input string tag);
      checks++;
      assert (gwIf.ip_o === mPend) else begin
         failures++;
         $error("[TB] FAIL %s ip_o observed=%h expected=%h", tag, gwIf.ip_o, mPend);
      end
      checks++;
      assert (gwIf.ia_o === mAct) else begin
         failures++;
         $error("[TB] FAIL %s ia_o observed=%h expected=%h", tag, gwIf.ia_o, mAct);
      end
      checks++;
      assert (gwIf.ovf_o === mOvf) else begin
         failures++;
         $error("[TB] FAIL %s ovf_o observed=%h expected=%h", tag, gwIf.ovf_o, mOvf);
      end
   endtask

   // Directed single-bit expectation derived by hand from the gateway rules
   task automatic checkBit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, advance model and DUT, then check
   task automatic applyStimulus(input logic [N-1:0] claim,
                                input logic [N-1:0] complete,
                                input logic [N-1:0] clr,
                                input string tag);
      gwIf.src_i      = srcV;
      gwIf.mode_i     = modeV;
      gwIf.claim_i    = claim;
      gwIf.complete_i = complete;
      gwIf.ovf_clr_i  = clr;
      modelStep(claim, complete, clr);
      @(posedge clk_i);
      #1;
      checkOutput(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int k = 0; k < n; k++) applyStimulus('0, '0, '0, tag);
   endtask

   // Claim everything then complete everything, with sources quiet
   task automatic drain(input int rounds);
      for (int r = 0; r < rounds; r++) begin
         applyStimulus('1, '0, '0, "drain_claim");
         applyStimulus('0, '1, '0, "drain_complete");
      end
   endtask

   initial begin
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] r3;
      logic [N-1:0] rc;
      logic [N-1:0] rd;
      logic [N-1:0] rk;

      gwIf.src_i      = '0;
      gwIf.mode_i     = '0;
      gwIf.claim_i    = '0;
      gwIf.complete_i = '0;
      gwIf.ovf_clr_i  = '0;
      modelReset();

      // Reset state
      #1 rst_ni = 1'b0;
      #1;
      checkOutput("reset");
      modeV[2*3 +: 2] = 2'b01;
      modeV[2*5 +: 2] = 2'b11;
      gwIf.mode_i     = modeV;
      @(posedge clk_i);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;

      // Level mode: latency SYNC+1, claim, complete with source still high
      srcV[0] = 1'b1;
      applyStimulus('0, '0, '0, "lvl_e1");
      applyStimulus('0, '0, '0, "lvl_e2");
      checkBit("lvl_ip_e2", gwIf.ip_o[0], 1'b0);
      applyStimulus('0, '0, '0, "lvl_e3");
      checkBit("lvl_ip_e3", gwIf.ip_o[0], 1'b1);
      applyStimulus(bitN(0), '0, '0, "lvl_claim");
      checkBit("lvl_claim_ip", gwIf.ip_o[0], 1'b0);
      checkBit("lvl_claim_ia", gwIf.ia_o[0], 1'b1);
      applyStimulus('0, bitN(0), '0, "lvl_complete");
      checkBit("lvl_complete_ia", gwIf.ia_o[0], 1'b0);
      applyStimulus('0, '0, '0, "lvl_retrig");
      checkBit("lvl_retrig_ip", gwIf.ip_o[0], 1'b1);
      srcV[0] = 1'b0;
      applyStimulus(bitN(0), '0, '0, "lvl_claim2");
      applyStimulus('0, bitN(0), '0, "lvl_complete2");
      idle(3, "lvl_quiet");
      checkBit("lvl_quiet_ia", gwIf.ia_o[0], 1'b0);

      // Rising mode: one-cycle pulse, then held high without re-trigger
      srcV[3] = 1'b1;
      applyStimulus('0, '0, '0, "rise_e1");
      srcV[3] = 1'b0;
      applyStimulus('0, '0, '0, "rise_e2");
      applyStimulus('0, '0, '0, "rise_e3");
      checkBit("rise_ip_e3", gwIf.ip_o[3], 1'b1);
      checkBit("rise_ia_e3", gwIf.ia_o[3], 1'b1);
      applyStimulus(bitN(3), '0, '0, "rise_claim");
      applyStimulus('0, bitN(3), '0, "rise_complete");
      checkBit("rise_done_ia", gwIf.ia_o[3], 1'b0);
      srcV[3] = 1'b1;
      idle(4, "rise_hold");
      applyStimulus(bitN(3), '0, '0, "rise_hold_claim");
      applyStimulus('0, bitN(3), '0, "rise_hold_complete");
      idle(4, "rise_hold_quiet");
      checkBit("rise_hold_ia", gwIf.ia_o[3], 1'b0);
      srcV[3] = 1'b0;
      idle(3, "rise_fall_ignored");
      checkBit("rise_fall_ignored_ia", gwIf.ia_o[3], 1'b0);

      // Both edges: three edges while in service, then service rounds
      srcV[5] = 1'b1;
      idle(3, "both_trig");
      checkBit("both_ip", gwIf.ip_o[5], 1'b1);
      applyStimulus(bitN(5), '0, '0, "both_claim");
      for (int t = 0; t < 3; t++) begin
         srcV[5] = ~srcV[5];
         idle(2, "both_toggle");
      end
      idle(2, "both_settle");
      checkBit("both_ovf_after3", gwIf.ovf_o[5], ~EDGE_CNT);
      checkBit("both_ia_serv", gwIf.ia_o[5], 1'b1);
      for (int r = 0; r < 3; r++) begin
         applyStimulus('0, bitN(5), '0, "both_round_complete");
         checkBit("both_round_ip", gwIf.ip_o[5], EDGE_CNT);
         applyStimulus(bitN(5), '0, '0, "both_round_claim");
      end
      applyStimulus('0, bitN(5), '0, "both_final_complete");
      checkBit("both_final_ia", gwIf.ia_o[5], 1'b0);
      applyStimulus('0, '0, bitN(5), "both_ovf_clr");
      checkBit("both_ovf_clr", gwIf.ovf_o[5], 1'b0);

      // Saturation, overflow clear, and clear coincident with a lost edge
      srcV[5] = 1'b1;
      idle(3, "sat_trig");
      applyStimulus(bitN(5), '0, '0, "sat_claim");
      for (int t = 0; t < 4; t++) begin
         srcV[5] = ~srcV[5];
         idle(2, "sat_toggle");
      end
      idle(2, "sat_settle");
      checkBit("sat_ovf_set", gwIf.ovf_o[5], 1'b1);
      applyStimulus('0, '0, bitN(5), "sat_ovf_clr");
      checkBit("sat_ovf_cleared", gwIf.ovf_o[5], 1'b0);
      srcV[5] = ~srcV[5];
      applyStimulus('0, '0, '0, "sat_lost_e1");
      applyStimulus('0, '0, '0, "sat_lost_e2");
      applyStimulus('0, '0, bitN(5), "sat_lost_clr");
      checkBit("sat_set_wins", gwIf.ovf_o[5], 1'b1);
      idle(1, "sat_sticky");
      checkBit("sat_sticky", gwIf.ovf_o[5], 1'b1);
      drain(5);
      checkBit("sat_drained_ia", gwIf.ia_o[5], 1'b0);

      // Random phase: sparse source toggles, random modes and handshakes
      for (int c = 0; c < 400; c++) begin
         if ((c % 32) == 0) begin
            r1    = $urandom;
            modeV = r1[2*N-1:0];
         end
         r1 = $urandom; r2 = $urandom; r3 = $urandom;
         srcV = srcV ^ (r1[N-1:0] & r2[N-1:0] & r3[N-1:0]);
         r1 = $urandom; r2 = $urandom;
         rc = r1[N-1:0] & r2[N-1:0];
         r1 = $urandom; r2 = $urandom;
         rd = r1[N-1:0] & r2[N-1:0];
         r1 = $urandom; r2 = $urandom; r3 = $urandom;
         rk = r1[N-1:0] & r2[N-1:0] & r3[N-1:0];
         applyStimulus(rc, rd, rk, "random");
      end

      // Quiesce everything before the reset scenario
      srcV = '0;
      idle(3, "quiet");
      drain(6);
      checkBit("drained_all", |gwIf.ia_o, 1'b0);
      applyStimulus('0, '0, '1, "clr_all");

      // Async reset while source 6 is in service with two queued edges
      modeV[2*6 +: 2] = 2'b11;
      idle(1, "rst_mode");
      srcV[6] = 1'b1;
      idle(3, "rst_trig");
      checkBit("rst_ip6", gwIf.ip_o[6], 1'b1);
      applyStimulus(bitN(6), '0, '0, "rst_claim");
      for (int t = 0; t < 2; t++) begin
         srcV[6] = ~srcV[6];
         idle(2, "rst_toggle");
      end
      idle(2, "rst_settle");
      checkBit("rst_serv_ia6", gwIf.ia_o[6], 1'b1);
      srcV          = '0;
      gwIf.src_i    = srcV;
      #2 rst_ni     = 1'b0;
      #1;
      modelReset();
      checkBit("rst_ip_zero", |gwIf.ip_o, 1'b0);
      checkBit("rst_ia_zero", |gwIf.ia_o, 1'b0);
      checkBit("rst_ovf_zero", |gwIf.ovf_o, 1'b0);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      idle(6, "post_reset");
      checkBit("post_reset_ia", |gwIf.ia_o, 1'b0);
      checkBit("post_reset_ip", |gwIf.ip_o, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rv_plic_gateway_mc.md
Name: rv_plic_gateway_mc

Overview:
- Multi-mode interrupt gateway between raw interrupt sources and the PLIC target/priority logic.
- Synchronises each source and applies a per-source trigger mode: level, rising, falling or both edges.
- Produces pending (ip) and active (ia) state per source through a claim/complete handshake.
- Counts edges that arrive while a source is busy, so bursts are not lost, and flags sticky overflow when the count saturates.

Parameters:
- N_SOURCE, 32, number of interrupt sources.
- CNT_W, 2, width of the per-source queued-edge counter; saturates at 2**CNT_W-1.
- SYNC_STAGES, 2, synchroniser flops per source; 0 means src_i is used directly.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- src_i  input  N_SOURCE  raw interrupt sources.
- mode_i  input  2*N_SOURCE  per-source mode, bits [2i+1:2i]:
  - 00 level-high
  - 01 rising edge
  - 10 falling edge
  - 11 both edges
- claim_i  input  N_SOURCE  per-source claim pulse from the target.
- complete_i  input  N_SOURCE  per-source completion pulse.
- ovf_clr_i  input  N_SOURCE  clears the sticky overflow flag.
- ip_o  output  N_SOURCE  interrupt pending.
- ia_o  output  N_SOURCE  interrupt active (pending or in service).
- ovf_o  output  N_SOURCE  sticky flag: an edge was lost.

Behaviour:
- Clock and reset: clk_i is the clock; rst_ni is the reset, asynchronous, active-low.
- Reset values: all flops reset to 0. This covers ip_o, ia_o, ovf_o, the counters, the synchroniser and the previous-sample register.
- Synchroniser: s[i] is src_i[i] passed through SYNC_STAGES flops. p[i] is s[i] delayed one cycle.
- Trigger event set[i], by mode:
  - level: s
  - rising: s & ~p
  - falling: ~s & p
  - both: s ^ p
- Latency: count the first edge that samples src_i high as edge 1. ip_o rises at clock edge SYNC_STAGES+1 for both level and edge modes.
- Per-source FSM, encoded in {ia,ip}:
  - IDLE = 00
  - PEND = 11
  - SERV = 10
- FSM transitions:
  - IDLE, set=1 -> PEND.
  - PEND, claim_i=1 -> SERV. A claim in IDLE or SERV is ignored.
  - SERV, complete_i=1, level mode -> IDLE. The level source re-triggers from IDLE the next cycle if still high.
  - SERV, complete_i=1, edge mode, cnt>0 -> PEND, cnt decrements by 1.
  - SERV, complete_i=1, edge mode, cnt=0, set=1 in the same cycle -> PEND; cnt stays 0.
  - SERV, complete_i=1, edge mode, cnt=0, set=0 -> IDLE.
  - A complete in IDLE or PEND is ignored.
- Edge queueing:
  - An edge-mode set while in PEND or SERV increments cnt, except for the complete-with-cnt=0 case above.
  - Set and complete with cnt>0 in the same cycle: cnt is unchanged and the state goes to PEND.
  - At cnt = 2**CNT_W-1 a further set leaves cnt saturated and sets ovf.
- Level mode: no queueing. cnt is forced to 0 every cycle while mode is 00.
- Mode changes: take effect the next cycle. The current FSM state is kept.
- Overflow flag: ovf_clr_i clears ovf. If set and clear occur in the same cycle, set wins.
- Simultaneous claim and complete: claim in PEND and complete in SERV cannot coincide, since the source is in one state. A complete in the same cycle as a claim on PEND is ignored.
- Reset mid-operation: every state returns to IDLE and queued edges are discarded.

Optional Feature:
- Macro: RV_PLIC_GW_EDGE_CNT_EN.
- Defined: edge queueing as above, with cnt of CNT_W bits per source.
- Undefined:
  - No counters are instantiated.
  - An edge arriving in PEND or SERV is dropped and sets ovf.
  - SERV+complete always goes to IDLE, unless set occurs in the same cycle, in which case it goes to PEND.
  - CNT_W is ignored.

Test Plan:
- Level mode, SYNC_STAGES=2: src[0] high from edge 1 -> ip_o[0]=1 at edge 3. Claim -> ip=0, ia=1. Complete with src still high -> PEND again 1 cycle later.
- Rising mode: pulse src[3] for 1 cycle -> ip_o[3]=1 at edge 3, ia_o[3]=1. Claim, then complete -> ip=ia=0. Holding src high causes no re-trigger.
- Both-edges mode with counter: during SERV, issue 3 src toggles (CNT_W=2) -> cnt=3, ovf=0. After 3 complete/claim rounds the source reaches IDLE.
- Saturation: during SERV, issue 4 edges -> ovf_o=1 and cnt=3. ovf_clr_i pulse -> ovf_o=0. ovf_clr_i coincident with a new lost edge -> ovf_o stays 1.
- Macro undefined: edge during PEND -> ovf_o=1. Complete -> IDLE, and no second interrupt is raised.
- Async reset asserted mid-SERV with cnt=2 -> ip_o, ia_o and ovf_o are 0 immediately. After release, no pending interrupt is raised without a new event.
